// File: rtl/regfile_dump_reader_if.sv
// Debug-path bundle between the register-file dump reader, the register-file read port
// and the downstream trace consumer.
interface regfile_dump_reader_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned IDX_W = 5
);

  logic             start;
  logic [IDX_W-1:0] first_reg;
  logic [IDX_W-1:0] last_reg;
  logic [IDX_W-1:0] rf_read_addr;
  logic [N-1:0]     rf_read_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             busy;
  logic             done;

  // Reader side: drives the read address and the output stream.
  modport master (
    input  start,
    input  first_reg,
    input  last_reg,
    input  rf_read_data,
    input  out_ready,
    output rf_read_addr,
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    output busy,
    output done
  );

  // Environment side: register file plus trace sink plus debug controller.
  modport slave (
    output start,
    output first_reg,
    output last_reg,
    output rf_read_data,
    output out_ready,
    input  rf_read_addr,
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a (possibly wrapping) register index range through a register-file read port
// and streams each captured 32-bit value out over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int unsigned N     = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_dump_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e           state_q,        state_d;
  logic [IDX_W-1:0] cur_idx_q,      cur_idx_d;
  logic [IDX_W-1:0] end_idx_q,      end_idx_d;
  logic [IDX_W-1:0] rf_read_addr_q, rf_read_addr_d;
  logic             out_valid_q,    out_valid_d;
  logic [N-1:0]     out_data_q,     out_data_d;
  logic [IDX_W-1:0] out_index_q,    out_index_d;
  logic             out_last_q,     out_last_d;
  logic             busy_q,         busy_d;
  logic             done_q,         done_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    end_idx_d   = end_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_idx_d = bus.first_reg;
          end_idx_d = bus.last_reg;
          busy_d    = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        out_data_d  = bus.rf_read_data;
        out_index_d = cur_idx_q;
        out_last_d  = (cur_idx_q == end_idx_q);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            // Index arithmetic is modulo 2^IDX_W so ranges may wrap past the top register.
            cur_idx_d = IDX_W'(cur_idx_q + IDX_W'(1));
            state_d   = READ;
          end
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Registered copy of the walk index, so the read port sees cur_idx for the whole READ cycle.
    rf_read_addr_d = cur_idx_d;
  end

  // All state and outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cur_idx_q      <= '0;
      end_idx_q      <= '0;
      rf_read_addr_q <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_index_q    <= '0;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_idx_q      <= cur_idx_d;
      end_idx_q      <= end_idx_d;
      rf_read_addr_q <= rf_read_addr_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_index_q    <= out_index_d;
      out_last_q     <= out_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.rf_read_addr = rf_read_addr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_index    = out_index_q;
  assign bus.out_last     = out_last_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
